if_fetch_stage: RTL

//  Instruction-fetch stage plus IF/ID pipeline register of the 5-stage RISC-V core.

---
 rtl/if_fetch_stage.sv | 131 +++++++++++++
 1 files changed

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage and IF/ID register: owns the PC, keeps at most one
// imem request in flight, and hands fetched instructions (or bubbles) to ID.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        PCWrite,
    input  logic        IF_ID_Write,
    input  logic        ex_BranchTaken,
    input  logic [31:0] ex_BranchTarget,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] id_PC,
    output logic [31:0] id_Instr,
    output logic        id_Valid
);
    localparam logic [2:0] S_BOOT = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_HOLD = 3'd3;
    localparam logic [2:0] S_DROP = 3'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_t;

    logic [2:0]  state, state_nxt;
    logic [31:0] pc, pc_nxt;
    fetch_t      hold_q, deliver_pkt;
    logic        hold_vld;
    logic        advance, deliver, capture;

    always_comb begin
        advance          = PCWrite & IF_ID_Write;
        deliver          = 1'b0;
        capture          = 1'b0;
        deliver_pkt.pc    = pc;
        deliver_pkt.instr = imem_rdata;
        state_nxt        = state;
        pc_nxt           = pc;

        case (state)
            S_BOOT: state_nxt = S_REQ;
            S_REQ:  if (imem_gnt) state_nxt = S_WAIT;
            S_WAIT: begin
                if (imem_rvalid) begin
                    if (advance) begin
                        deliver   = 1'b1;
                        state_nxt = S_REQ;
                    end else begin
                        capture   = 1'b1;
                        state_nxt = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (advance && hold_vld) begin
                    deliver     = 1'b1;
                    deliver_pkt = hold_q;
                    state_nxt   = S_REQ;
                end
            end
            S_DROP: if (imem_rvalid) state_nxt = S_REQ;
            default: state_nxt = S_BOOT;
        endcase

        if (deliver) pc_nxt = pc + 32'd4;

        // A redirect wins over everything; a response still in flight must be dropped.
        // If the dropped response lands in the same cycle, nothing is left outstanding.
        if (ex_BranchTaken) begin
            deliver = 1'b0;
            capture = 1'b0;
            pc_nxt  = ex_BranchTarget;
            case (state)
                S_REQ:   state_nxt = imem_gnt    ? S_DROP : S_REQ;
                S_WAIT:  state_nxt = imem_rvalid ? S_REQ  : S_DROP;
                S_DROP:  state_nxt = imem_rvalid ? S_REQ  : S_DROP;
                default: state_nxt = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_BOOT;
            pc       <= RESET_PC;
            hold_q   <= '0;
            hold_vld <= 1'b0;
            id_PC    <= 32'd0;
            id_Instr <= NOP_INSTR;
            id_Valid <= 1'b0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;

            if (capture) begin
                hold_q.pc    <= pc;
                hold_q.instr <= imem_rdata;
                hold_vld     <= 1'b1;
            end else if (deliver || ex_BranchTaken) begin
                hold_vld <= 1'b0;
            end

            // Bubbles keep id_PC so ID always sees the PC of the last real slot.
            if (ex_BranchTaken) begin
                id_Instr <= NOP_INSTR;
                id_Valid <= 1'b0;
            end else if (advance) begin
                if (deliver) begin
                    id_PC    <= deliver_pkt.pc;
                    id_Instr <= deliver_pkt.instr;
                    id_Valid <= 1'b1;
                end else begin
                    id_Instr <= NOP_INSTR;
                    id_Valid <= 1'b0;
                end
            end
        end
    end

    assign imem_req  = (state == S_REQ);
    assign imem_addr = pc;

endmodule
